// File: rtl/tile_serializer_2d_if.sv
// tile_serializer_2d_if
//
// Handshake and data bundle for tile_serializer_2d.
//
// Signals:
//   ivalid  master -> slave  idata holds a complete tile
//   iready  slave  -> master block accepts a tile this cycle
//   idata   master -> slave  tile, indexed [feature][element]
//   ovalid  slave  -> master odata holds a valid row beat
//   oready  master -> slave  downstream accepts the beat
//   odata   slave  -> master current row, indexed [element]
//   orow    slave  -> master index of the current row
//   olast   slave  -> master current beat is the final row of the tile
//
// Modports:
//   master  the side that supplies tiles and consumes rows (the environment)
//   slave   the serializer itself

interface tile_serializer_2d_if #(
  parameter int unsigned NUM_FEATURES = 4,
  parameter int unsigned N            = 4,
  parameter int unsigned PRECISION    = 4
) ();

  // orow is at least one bit wide, even for single-row tiles.
  localparam int unsigned RowW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;

  logic                                         ivalid;
  logic                                         iready;
  logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] idata;

  logic                                         ovalid;
  logic                                         oready;
  logic [N-1:0][PRECISION-1:0]                  odata;
  logic [RowW-1:0]                              orow;
  logic                                         olast;

  modport master (
    output ivalid,
    output idata,
    output oready,
    input  iready,
    input  ovalid,
    input  odata,
    input  orow,
    input  olast
  );

  modport slave (
    input  ivalid,
    input  idata,
    input  oready,
    output iready,
    output ovalid,
    output odata,
    output orow,
    output olast
  );

endinterface

// File: rtl/tile_serializer_2d.sv
// tile_serializer_2d
//
// Unpacks a parallel [NUM_FEATURES][N] tile into NUM_FEATURES row beats, feature 0 first,
// one row of N elements per beat, with valid/ready flow control on both sides.
//
// A tile is captured whole on accept; rows are then replayed from the internal tile register
// while the input side is stalled. On the transfer of the final row a new tile may be accepted
// in the same cycle, so back-to-back tiles stream with no bubble.
//
// Ports:
//   clk    single clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   bus    tile_serializer_2d_if.slave
//            ivalid/iready/idata  tile input handshake
//            ovalid/oready        row output handshake
//            odata/orow/olast     current row, its index, final-row flag (all 0 when idle)

module tile_serializer_2d #(
  parameter int unsigned NUM_FEATURES = 4,
  parameter int unsigned N            = 4,
  parameter int unsigned PRECISION    = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  tile_serializer_2d_if.slave bus
);

  localparam int unsigned     RowW    = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam logic [RowW-1:0] LastRow = RowW'(NUM_FEATURES - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StSend = 1'b1;

  typedef logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] tile_t;
  typedef logic [N-1:0][PRECISION-1:0]                   row_t;

  logic [0:0]      state_q, state_d;
  logic [RowW-1:0] row_q,   row_d;
  tile_t           tile_q,  tile_d;

  logic send;
  logic last_row;
  logic beat_xfer;
  logic in_ready;
  logic tile_accept;

  // Handshake decode. in_ready depends on oready but never on ivalid, so an upstream that
  // waits for iready before raising ivalid cannot form a loop through this block.
  always_comb begin
    send        = (state_q == StSend);
    last_row    = (row_q == LastRow);
    beat_xfer   = send && bus.oready;
    in_ready    = !send || (beat_xfer && last_row);
    tile_accept = bus.ivalid && in_ready;
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    tile_d  = tile_q;

    if (tile_accept) begin
      // Covers both the idle accept and the reload on the final-row transfer.
      state_d = StSend;
      row_d   = '0;
      tile_d  = bus.idata;
    end else if (beat_xfer) begin
      if (last_row) begin
        state_d = StIdle;
        row_d   = '0;
      end else begin
        row_d   = row_q + RowW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      row_q   <= '0;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      tile_q  <= tile_d;
    end
  end

  // Output beat comes straight from registered state, so it holds while stalled.
  row_t row_sel;

  always_comb begin
    row_sel = tile_q[row_q];
  end

  assign bus.iready = in_ready;
  assign bus.ovalid = send;
  assign bus.odata  = send ? row_sel : '0;
  assign bus.orow   = send ? row_q : '0;
  assign bus.olast  = send && last_row;

endmodule
